usart_tx_sched: RTL and testbench

Round-robin scheduler that shares the single `usart_tx` byte transmitter among `NUM_REQ` byte-stream requesters. Each requester offers bytes on a valid/ready handshake. The scheduler grants one byte at a time, presents it on `usart_din`, and raises `usart_en` so the transmitter sees a rising edge. It tracks `usart_tx_busy` to frame completion, recovers if the transmitter never responds, and guarantees `usart_en` is low long enough for the transmitter's 2-stage edge detector before the next byte.

---
 rtl/usart_tx_sched_if.sv | 22 ++
 rtl/usart_tx_sched.sv | 166 ++++++++++++++++
 tb/tb_usart_tx_sched.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/usart_tx_sched_if.sv
// Requester and transmitter signals shared by usart_tx_sched and its environment.
// master: requesters plus the usart_tx busy feedback; slave: the scheduler.
interface usart_tx_sched_if #(
    parameter int unsigned NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 usart_en;
    logic [7:0]           usart_din;
    logic                 usart_tx_busy;

    modport master (
        output req_valid, req_data, usart_tx_busy,
        input  req_ready, usart_en, usart_din
    );

    modport slave (
        input  req_valid, req_data, usart_tx_busy,
        output req_ready, usart_en, usart_din
    );
endinterface

// File: rtl/usart_tx_sched.sv
// Round-robin scheduler sharing one usart_tx byte transmitter among NUM_REQ requesters.
// One byte is granted at a time.
// usart_en is held low for at least GAP_CYCLES+1 cycles between frames so that the
// transmitter's edge detector always sees a fresh rising edge.
module usart_tx_sched #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned BUSY_TIMEOUT = 8,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       sched_en,
    usart_tx_sched_if.slave            bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       sched_busy,
    output logic                       tx_timeout,
    output logic [15:0]                frame_cnt
);
    localparam int unsigned IdW      = $clog2(NUM_REQ);
    localparam int unsigned TimerMax = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
    localparam int unsigned TimerW   = $clog2(TimerMax + 1);

    typedef enum logic [1:0] {StIdle, StStart, StWaitTx, StGap} state_e;

    state_e              state_q, state_d;
    logic                armed_q, armed_d;
    logic [IdW-1:0]      last_q, last_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic                usart_en_q, usart_en_d;
    logic [7:0]          usart_din_q, usart_din_d;
    logic [IdW-1:0]      grant_id_q, grant_id_d;
    logic                tx_timeout_q, tx_timeout_d;
    logic                sched_busy_q, sched_busy_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    logic                found;
    logic [IdW-1:0]      gnt_idx;
    logic [IdW-1:0]      cand;
    logic [7:0]          gnt_byte;
    logic                accept;

    // Cyclic search for the first valid channel, starting just after the last grant.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = IdW'((32'(last_q) + off) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Select the granted channel's byte.
    always_comb begin
        gnt_byte = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IdW'(i) == gnt_idx) begin
                gnt_byte = bus.req_data[8*i +: 8];
            end
        end
    end

    // Readiness is suppressed on the very first cycle after reset release (armed low).
    assign accept = armed_q && (state_q == StIdle) && sched_en && found;

    // One-hot ready towards the winning requester.
    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    // Next-state and registered-output logic of the grant FSM.
    always_comb begin
        state_d      = state_q;
        armed_d      = 1'b1;
        last_d       = last_q;
        timer_d      = timer_q;
        usart_en_d   = usart_en_q;
        usart_din_d  = usart_din_q;
        grant_id_d   = grant_id_q;
        tx_timeout_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d     = StStart;
                    usart_en_d  = 1'b1;
                    usart_din_d = gnt_byte;
                    grant_id_d  = gnt_idx;
                    last_d      = gnt_idx;
                    timer_d     = '0;
                end
            end
            StStart: begin
                timer_d = timer_q + 1'b1;
                // Busy wins over a timeout reached in the same cycle.
                if (bus.usart_tx_busy) begin
                    usart_en_d = 1'b0;
                    state_d    = StWaitTx;
                end else if (timer_q == TimerW'(BUSY_TIMEOUT - 1)) begin
                    usart_en_d   = 1'b0;
                    tx_timeout_d = 1'b1;
                    state_d      = StGap;
                    timer_d      = '0;
                end
            end
            StWaitTx: begin
                if (!bus.usart_tx_busy) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = StGap;
                    timer_d     = '0;
                end
            end
            StGap: begin
                if (timer_q == TimerW'(GAP_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        sched_busy_d = (state_d != StIdle);
    end

    // State and output registers; reset drops usart_en asynchronously.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= StIdle;
            armed_q      <= 1'b0;
            last_q       <= IdW'(NUM_REQ - 1);
            timer_q      <= '0;
            usart_en_q   <= 1'b0;
            usart_din_q  <= '0;
            grant_id_q   <= '0;
            tx_timeout_q <= 1'b0;
            sched_busy_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            last_q       <= last_d;
            timer_q      <= timer_d;
            usart_en_q   <= usart_en_d;
            usart_din_q  <= usart_din_d;
            grant_id_q   <= grant_id_d;
            tx_timeout_q <= tx_timeout_d;
            sched_busy_q <= sched_busy_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign bus.usart_en  = usart_en_q;
    assign bus.usart_din = usart_din_q;
    assign grant_id      = grant_id_q;
    assign sched_busy    = sched_busy_q;
    assign tx_timeout    = tx_timeout_q;
    assign frame_cnt     = frame_cnt_q;
endmodule

// File: tb/tb_usart_tx_sched.sv
// Directed bench for usart_tx_sched with a small usart_tx busy stub.
module tb_usart_tx_sched;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        sched_en;
    logic [1:0]  grant_id;
    logic        sched_busy;
    logic        tx_timeout;
    logic [15:0] frame_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int low;

    // Busy stub: 2-stage edge detect on usart_en, busy for stub_len cycles from edge k+2.
    logic        stub_on;
    int          stub_len;
    logic        en_d1, en_d2;
    int          busy_cnt;
    logic [7:0]  cap_byte;

    usart_tx_sched_if #(.NUM_REQ(4)) bus ();

    usart_tx_sched #(
        .NUM_REQ     (4),
        .BUSY_TIMEOUT(8),
        .GAP_CYCLES  (2)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .sched_en  (sched_en),
        .bus       (bus),
        .grant_id  (grant_id),
        .sched_busy(sched_busy),
        .tx_timeout(tx_timeout),
        .frame_cnt (frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // Transmitter stand-in driving usart_tx_busy.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            en_d1             <= 1'b0;
            en_d2             <= 1'b0;
            busy_cnt          <= 0;
            bus.usart_tx_busy <= 1'b0;
            cap_byte          <= 8'h00;
        end else begin
            en_d1 <= bus.usart_en;
            en_d2 <= en_d1;
            if (busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) bus.usart_tx_busy <= 1'b0;
            end else if (stub_on && en_d1 && !en_d2) begin
                bus.usart_tx_busy <= 1'b1;
                busy_cnt          <= stub_len;
                cap_byte          <= bus.usart_din;
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for usart_en to fall then rise again; returns the cycles it spent low.
    task automatic wait_en(output int low_cnt);
        int n;
        n = 0;
        while (bus.usart_en === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        low_cnt = 0;
        while (bus.usart_en !== 1'b1 && low_cnt < 60) begin
            tick();
            low_cnt++;
        end
        chk("en_rise", bus.usart_en, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sched_busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        chk("idle_reached", sched_busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        sys_rst_n     = 1'b0;
        sched_en      = 1'b1;
        stub_on       = 1'b1;
        stub_len      = 4;
        bus.req_valid = 4'b0100;
        bus.req_data  = 32'h00A5_0000;
        #1;
        // Reset values
        chk("rst_en", bus.usart_en, 0);
        chk("rst_din", bus.usart_din, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_busy", sched_busy, 0);
        chk("rst_timeout", tx_timeout, 0);
        chk("rst_cnt", frame_cnt, 0);
        chk("rst_ready", bus.req_ready, 0);
        tick();
        tick();
        sys_rst_n = 1'b1;
        #1;
        chk("unarmed_ready", bus.req_ready, 4'b0000);

        // Single channel 2, byte 0xA5
        tick();
        chk("t1_ready", bus.req_ready, 4'b0100);
        chk("t1_en_pre", bus.usart_en, 0);
        tick();
        chk("t1_en", bus.usart_en, 1);
        chk("t1_din", bus.usart_din, 8'hA5);
        chk("t1_grant", grant_id, 2);
        chk("t1_ready_busy", bus.req_ready, 0);
        chk("t1_sched_busy", sched_busy, 1);
        bus.req_valid = 4'b0000;
        tick();
        tick();
        chk("t1_stub_busy", bus.usart_tx_busy, 1);
        chk("t1_en_held", bus.usart_en, 1);
        tick();
        chk("t1_en_fall", bus.usart_en, 0);
        tick();
        tick();
        tick();
        chk("t1_cnt_pre", frame_cnt, 0);
        tick();
        chk("t1_cnt", frame_cnt, 1);
        chk("t1_gap_busy", sched_busy, 1);
        tick();
        tick();
        chk("t1_idle", sched_busy, 0);
        chk("t1_captured", cap_byte, 8'hA5);

        // Busy never rises: timeout after BUSY_TIMEOUT cycles
        stub_on       = 1'b0;
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h0000_005A;
        tick();
        chk("t3_en", bus.usart_en, 1);
        chk("t3_grant", grant_id, 0);
        chk("t3_din", bus.usart_din, 8'h5A);
        bus.req_valid = 4'b0000;
        repeat (7) tick();
        chk("t3_no_timeout", tx_timeout, 0);
        chk("t3_en_held", bus.usart_en, 1);
        tick();
        chk("t3_timeout", tx_timeout, 1);
        chk("t3_en_drop", bus.usart_en, 0);
        chk("t3_cnt_same", frame_cnt, 1);
        chk("t3_gap_busy", sched_busy, 1);
        bus.req_valid = 4'b0010;
        bus.req_data  = 32'h0000_3C00;
        stub_on       = 1'b1;
        tick();
        chk("t3_pulse_end", tx_timeout, 0);
        chk("t3_gap_en1", bus.usart_en, 0);
        tick();
        chk("t3_gap_en2", bus.usart_en, 0);
        chk("t3_idle", sched_busy, 0);
        chk("t3_ready_next", bus.req_ready, 4'b0010);
        tick();
        chk("t3_next_en", bus.usart_en, 1);
        chk("t3_next_grant", grant_id, 1);
        chk("t3_next_din", bus.usart_din, 8'h3C);
        bus.req_valid = 4'b0000;

        // sched_en dropped during WAIT_TX
        tick();
        tick();
        tick();
        chk("t4_wait_en", bus.usart_en, 0);
        tick();
        sched_en      = 1'b0;
        bus.req_valid = 4'b0100;
        bus.req_data  = 32'h0077_0000;
        tick();
        tick();
        tick();
        chk("t4_cnt", frame_cnt, 2);
        tick();
        tick();
        chk("t4_idle", sched_busy, 0);
        chk("t4_ready_off", bus.req_ready, 0);
        tick();
        tick();
        tick();
        chk("t4_ready_off2", bus.req_ready, 0);
        chk("t4_no_en", bus.usart_en, 0);
        chk("t4_still_idle", sched_busy, 0);
        sched_en = 1'b1;
        #1;
        chk("t4_ready_on", bus.req_ready, 4'b0100);
        tick();
        chk("t4_en", bus.usart_en, 1);
        chk("t4_grant", grant_id, 2);
        chk("t4_din", bus.usart_din, 8'h77);

        // Reset mid-frame, then strict rotation from channel 0
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'h1312_1110;
        tick();
        tick();
        sys_rst_n = 1'b0;
        #1;
        chk("t5_en_async", bus.usart_en, 0);
        chk("t5_busy_async", sched_busy, 0);
        chk("t5_cnt_async", frame_cnt, 0);
        chk("t5_grant_async", grant_id, 0);
        chk("t5_din_async", bus.usart_din, 0);
        tick();
        sys_rst_n = 1'b1;
        #1;
        chk("t5_unarmed", bus.req_ready, 4'b0000);
        tick();
        chk("t5_ready0", bus.req_ready, 4'b0001);
        tick();
        chk("t5_en", bus.usart_en, 1);
        chk("t5_grant0", grant_id, 0);
        chk("t5_din0", bus.usart_din, 8'h10);
        for (int g = 1; g <= 4; g++) begin
            wait_en(low);
            chk("rot_grant", grant_id, g % 4);
            chk("rot_din", bus.usart_din, 32'h10 + (g % 4));
            chk("rot_low_ge3", low >= 3, 1);
        end
        bus.req_valid = 4'b0000;
        chk("rot_cnt", frame_cnt, 4);

        // Counter wrap 0xFFFF -> 0
        wait_idle();
        force dut.frame_cnt_q = 16'hFFFF;
        tick();
        release dut.frame_cnt_q;
        #1;
        chk("t6_preload", frame_cnt, 16'hFFFF);
        bus.req_valid = 4'b0010;
        bus.req_data  = 32'h0000_C300;
        wait_en(low);
        bus.req_valid = 4'b0000;
        chk("t6_grant", grant_id, 1);
        tick();
        wait_idle();
        chk("t6_wrap", frame_cnt, 16'h0000);
        chk("t6_captured", cap_byte, 8'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
